// File: rtl/dsp_be_prbs_chk_if.sv
// rtl/dsp_be_prbs_chk_if.sv - received-word stream in, per-bit error flags out
interface dsp_be_prbs_chk_if #(
    parameter int PRLL_RANK = 16
);
    logic                 i_vld;
    logic [PRLL_RANK-1:0] i_drx;
    logic [PRLL_RANK-1:0] o_err;
    logic                 o_err_vld;

    modport master (output i_vld, i_drx, input  o_err, o_err_vld);
    modport slave  (input  i_vld, i_drx, output o_err, o_err_vld);
endinterface

// File: rtl/dsp_be_prbs_chk.sv
// rtl/dsp_be_prbs_chk.sv - parallel PRBS7/15/31 checker with lock FSM and saturating BER counters
module dsp_be_prbs_chk #(
    parameter int PRLL_RANK       = 16,
    parameter int BER_COUNT_WIDTH = 41,
    parameter int LOCK_WORDS      = 8,
    parameter int UNLOCK_WORDS    = 4
) (
    input  logic                       i_clk,
    input  logic                       i_rst_n,
    dsp_be_prbs_chk_if.slave           rx,
    input  logic [1:0]                 i_cfg_prbs_sel,
    input  logic                       i_cfg_in_inv,
    input  logic                       i_cfg_count_en,
    input  logic [3:0]                 i_cfg_shutoff_sel,
    input  logic                       i_clr,
    output logic                       o_locked,
    output logic [BER_COUNT_WIDTH-1:0] o_bit_count,
    output logic [BER_COUNT_WIDTH-1:0] o_ber_count,
    output logic                       o_shutoff
);
    localparam int EXT_W   = PRLL_RANK + 31;
    localparam int CW1     = BER_COUNT_WIDTH + 1;
    localparam int PCW     = $clog2(PRLL_RANK + 1);
    localparam int CNT_TOP = (LOCK_WORDS > UNLOCK_WORDS) ? LOCK_WORDS : UNLOCK_WORDS;
    localparam int LCW     = $clog2(CNT_TOP + 1);

    typedef enum logic {HUNT = 1'b0, LOCKED = 1'b1} state_t;

    state_t               state;
    logic [LCW-1:0]       lock_cnt;
    logic [1:0]           sel_q;
    logic [30:0]          hist;
    logic [PRLL_RANK-1:0] d;
    logic [PRLL_RANK-1:0] pred;
    logic [EXT_W-1:0]     ext;
    logic [PCW-1:0]       err_pop;
    logic [CW1-1:0]       bit_sum;
    logic [CW1-1:0]       ber_sum;
    logic [15:0]          shut_bits;
    logic                 clean;
    logic                 count_go;
    logic                 shut_hit;

    function automatic logic [PCW-1:0] popcount(input logic [PRLL_RANK-1:0] v);
        logic [PCW-1:0] c;
        c = '0;
        for (int i = 0; i < PRLL_RANK; i++) begin
            c = c + PCW'(v[i]);
        end
        return c;
    endfunction

    // ext holds the current word above the 31 previous bits; hist[30] is the bit just before d[0]
    assign d   = rx.i_drx ^ {PRLL_RANK{i_cfg_in_inv}};
    assign ext = {d, hist};

    always_comb begin
        pred = '0;
        for (int n = 0; n < PRLL_RANK; n++) begin
            case (i_cfg_prbs_sel)
                2'd0:    pred[n] = ext[31 + n - 7]  ^ ext[31 + n - 6];
                2'd1:    pred[n] = ext[31 + n - 15] ^ ext[31 + n - 14];
                default: pred[n] = ext[n]           ^ ext[31 + n - 28];
            endcase
        end
    end

    assign clean     = (rx.o_err == '0);
    assign err_pop   = popcount(rx.o_err);
    assign bit_sum   = {1'b0, o_bit_count} + CW1'(PRLL_RANK);
    assign ber_sum   = {1'b0, o_ber_count} + CW1'(err_pop);
    assign count_go  = rx.o_err_vld & o_locked & i_cfg_count_en & ~o_shutoff;
    assign shut_bits = o_bit_count[BER_COUNT_WIDTH-1 -: 16];
    assign shut_hit  = (i_cfg_shutoff_sel != 4'd0) && shut_bits[i_cfg_shutoff_sel];
    assign o_locked  = (state == LOCKED);

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state        <= HUNT;
            lock_cnt     <= '0;
            sel_q        <= 2'd0;
            hist         <= '0;
            rx.o_err     <= '0;
            rx.o_err_vld <= 1'b0;
            o_bit_count  <= '0;
            o_ber_count  <= '0;
            o_shutoff    <= 1'b0;
        end else begin
            sel_q        <= i_cfg_prbs_sel;
            rx.o_err_vld <= rx.i_vld;
            if (rx.i_vld) begin
                hist     <= ext[EXT_W-1 -: 31];
                rx.o_err <= d ^ pred;
            end

            // FSM judges the registered flags so lock decisions lag the error output by one cycle
            if (i_cfg_prbs_sel != sel_q) begin
                state    <= HUNT;
                lock_cnt <= '0;
            end else if (rx.o_err_vld) begin
                case (state)
                    HUNT: begin
                        if (!clean) begin
                            lock_cnt <= '0;
                        end else if (lock_cnt == LCW'(LOCK_WORDS - 1)) begin
                            state    <= LOCKED;
                            lock_cnt <= '0;
                        end else begin
                            lock_cnt <= lock_cnt + LCW'(1);
                        end
                    end
                    default: begin
                        if (clean) begin
                            lock_cnt <= '0;
                        end else if (lock_cnt == LCW'(UNLOCK_WORDS - 1)) begin
                            state    <= HUNT;
                            lock_cnt <= '0;
                        end else begin
                            lock_cnt <= lock_cnt + LCW'(1);
                        end
                    end
                endcase
            end

            if (i_clr) begin
                o_bit_count <= '0;
                o_ber_count <= '0;
                o_shutoff   <= 1'b0;
            end else begin
                if (shut_hit) begin
                    o_shutoff <= 1'b1;
                end
                if (count_go) begin
                    o_bit_count <= bit_sum[CW1-1] ? '1 : bit_sum[BER_COUNT_WIDTH-1:0];
                    o_ber_count <= ber_sum[CW1-1] ? '1 : ber_sum[BER_COUNT_WIDTH-1:0];
                end
            end
        end
    end
endmodule

// File: tb/tb_dsp_be_prbs_chk.sv
// tb/tb_dsp_be_prbs_chk.sv - directed/randomized PRBS checker bench against a bit-history reference model
module tb_dsp_be_prbs_chk;
    localparam int W            = 16;
    localparam int BCW          = 41;
    localparam int LOCK_WORDS   = 8;
    localparam int UNLOCK_WORDS = 4;
    localparam longint unsigned CMAX = (64'd1 << BCW) - 64'd1;

    logic           clk;
    logic           rst_n;
    logic [1:0]     prbs_sel;
    logic           in_inv;
    logic           count_en;
    logic [3:0]     shutoff_sel;
    logic           clr;
    logic           locked;
    logic [BCW-1:0] bit_count;
    logic [BCW-1:0] ber_count;
    logic           shutoff;

    int checks   = 0;
    int failures = 0;

    dsp_be_prbs_chk_if #(.PRLL_RANK(W)) rx ();

    dsp_be_prbs_chk #(
        .PRLL_RANK(W), .BER_COUNT_WIDTH(BCW),
        .LOCK_WORDS(LOCK_WORDS), .UNLOCK_WORDS(UNLOCK_WORDS)
    ) dut (
        .i_clk(clk), .i_rst_n(rst_n), .rx(rx),
        .i_cfg_prbs_sel(prbs_sel), .i_cfg_in_inv(in_inv), .i_cfg_count_en(count_en),
        .i_cfg_shutoff_sel(shutoff_sel), .i_clr(clr),
        .o_locked(locked), .o_bit_count(bit_count), .o_ber_count(ber_count), .o_shutoff(shutoff)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // reference model state: everything seen at the outputs after the last edge
    bit             hb[$];
    logic [W-1:0]   m_err;
    logic           m_err_vld;
    logic           m_locked;
    int             m_cnt;
    logic [1:0]     m_sel_q;
    logic [BCW-1:0] m_bit;
    logic [BCW-1:0] m_ber;
    logic           m_shut;

    // pattern source
    bit src[$];
    int src_a, src_b;

    task automatic src_start(input int a, input int b, input logic [30:0] seed);
        src.delete();
        src_a = a;
        src_b = b;
        for (int i = 0; i < a; i++) src.push_back(seed[i]);
    endtask

    function automatic logic [W-1:0] src_word();
        logic [W-1:0] w;
        for (int i = 0; i < W; i++) begin
            w[i] = src[0];
            src.push_back(src[0] ^ src[src_a - src_b]);
            void'(src.pop_front());
        end
        return w;
    endfunction

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        hb.delete();
        for (int i = 0; i < 31; i++) hb.push_back(1'b0);
        m_err = '0; m_err_vld = 1'b0; m_locked = 1'b0; m_cnt = 0;
        m_sel_q = 2'd0; m_bit = '0; m_ber = '0; m_shut = 1'b0;
    endtask

    task automatic model_edge(input logic vld, input logic [W-1:0] word);
        logic [W-1:0]    d, e;
        int              a, b, len, idx;
        logic            clean, go, nx_locked, nx_shut;
        int              nx_cnt;
        logic [BCW-1:0]  nx_bit, nx_ber;
        longint unsigned sum;
        nx_locked = m_locked; nx_cnt = m_cnt; nx_bit = m_bit; nx_ber = m_ber; nx_shut = m_shut;
        clean = (m_err == '0);
        if (prbs_sel != m_sel_q) begin
            nx_locked = 1'b0; nx_cnt = 0;
        end else if (m_err_vld) begin
            if (m_locked == clean) begin
                nx_cnt = 0;
            end else begin
                nx_cnt = m_cnt + 1;
                if (!m_locked && nx_cnt == LOCK_WORDS) begin nx_locked = 1'b1; nx_cnt = 0; end
                if (m_locked && nx_cnt == UNLOCK_WORDS) begin nx_locked = 1'b0; nx_cnt = 0; end
            end
        end
        go = m_err_vld && m_locked && count_en && !m_shut;
        if (clr) begin
            nx_bit = '0; nx_ber = '0; nx_shut = 1'b0;
        end else begin
            idx = BCW - 16 + int'(shutoff_sel);
            if (shutoff_sel != 4'd0 && m_bit[idx]) nx_shut = 1'b1;
            if (go) begin
                sum = 64'(m_bit) + 64'(W);
                nx_bit = (sum > CMAX) ? BCW'(CMAX) : BCW'(sum);
                sum = 64'(m_ber) + 64'($countones(m_err));
                nx_ber = (sum > CMAX) ? BCW'(CMAX) : BCW'(sum);
            end
        end
        if (vld) begin
            d = word ^ {W{in_inv}};
            case (prbs_sel)
                2'd0:    begin a = 7;  b = 6;  end
                2'd1:    begin a = 15; b = 14; end
                default: begin a = 31; b = 28; end
            endcase
            len = hb.size();
            for (int i = 0; i < W; i++) hb.push_back(d[i]);
            for (int n = 0; n < W; n++) e[n] = d[n] ^ hb[len + n - a] ^ hb[len + n - b];
            while (hb.size() > 64) void'(hb.pop_front());
            m_err = e;
        end
        m_err_vld = vld; m_sel_q = prbs_sel;
        m_locked = nx_locked; m_cnt = nx_cnt; m_bit = nx_bit; m_ber = nx_ber; m_shut = nx_shut;
    endtask

    task automatic check_all();
        chk("err", 64'(rx.o_err), 64'(m_err));
        chk("err_vld", 64'(rx.o_err_vld), 64'(m_err_vld));
        chk("locked", 64'(locked), 64'(m_locked));
        chk("bit_count", 64'(bit_count), 64'(m_bit));
        chk("ber_count", 64'(ber_count), 64'(m_ber));
        chk("shutoff", 64'(shutoff), 64'(m_shut));
    endtask

    task automatic check_zero(input string tag);
        chk({tag, "_err"}, 64'(rx.o_err), 64'd0);
        chk({tag, "_err_vld"}, 64'(rx.o_err_vld), 64'd0);
        chk({tag, "_locked"}, 64'(locked), 64'd0);
        chk({tag, "_bit"}, 64'(bit_count), 64'd0);
        chk({tag, "_ber"}, 64'(ber_count), 64'd0);
        chk({tag, "_shut"}, 64'(shutoff), 64'd0);
    endtask

    task automatic step(input logic vld, input logic [W-1:0] word);
        @(negedge clk);
        rx.i_vld = vld;
        rx.i_drx = word;
        model_edge(vld, word);
        @(posedge clk);
        #1;
        check_all();
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst_n = 1'b0;
        model_reset();
        #1;
        check_zero("reset");
        @(posedge clk);
        #1;
        rst_n = 1'b1;
    endtask

    initial begin
        logic [W-1:0]   mask;
        logic [BCW-1:0] saved;
        int p0, p1, p2;
        rst_n = 1'b0; prbs_sel = 2'd0; in_inv = 1'b0; count_en = 1'b1;
        shutoff_sel = 4'd0; clr = 1'b0; rx.i_vld = 1'b0; rx.i_drx = '0;
        model_reset();
        do_reset();

        // PRBS7 lock and 100-word count
        src_start(7, 6, 31'h7F);
        for (int k = 0; k < 10; k++) step(1'b1, src_word());
        chk("prbs7_locked_by_10", 64'(locked), 64'd1);
        for (int k = 0; k < 100; k++) step(1'b1, src_word());
        chk("prbs7_bit_1600", 64'(bit_count), 64'd1600);
        chk("prbs7_ber_0", 64'(ber_count), 64'd0);

        // polynomial change drops lock on the next edge, counters kept
        prbs_sel = 2'd1;
        step(1'b1, src_word());
        chk("sel_change_unlock", 64'(locked), 64'd0);
        chk("sel_change_bit_kept", 64'(bit_count), 64'd1616);

        // PRBS15 relock with idle cycles, then 4 errored words
        src_start(15, 14, 31'h7FFF);
        for (int k = 0; k < 12; k++) step(1'b1, src_word());
        step(1'b0, 16'($urandom));
        step(1'b0, 16'($urandom));
        chk("prbs15_locked", 64'(locked), 64'd1);
        for (int k = 0; k < 4; k++) step(1'b1, ~src_word());
        chk("prbs15_still_locked", 64'(locked), 64'd1);
        step(1'b1, src_word());
        chk("prbs15_unlocked", 64'(locked), 64'd0);
        saved = m_bit;
        for (int k = 0; k < 3; k++) step(1'b1, src_word());
        chk("prbs15_count_stopped", 64'(bit_count), 64'(saved));

        // PRBS31, flip three bits of one locked word
        prbs_sel = 2'd2;
        src_start(31, 28, 31'($urandom) | 31'd1);
        for (int k = 0; k < 14; k++) step(1'b1, src_word());
        chk("prbs31_locked", 64'(locked), 64'd1);
        p0 = $urandom_range(0, 4);
        p1 = p0 + 1 + $urandom_range(0, 4);
        p2 = p1 + 1 + $urandom_range(0, 4);
        mask = '0; mask[p0] = 1'b1; mask[p1] = 1'b1; mask[p2] = 1'b1;
        step(1'b1, src_word() ^ mask);
        chk("prbs31_three_flags", 64'($countones(rx.o_err)), 64'd3);
        for (int k = 0; k < 4; k++) step(1'b1, src_word());
        chk("prbs31_stays_locked", 64'(locked), 64'd1);

        // inverted PRBS7: no lock without in_inv, lock with it
        prbs_sel = 2'd0;
        do_reset();
        src_start(7, 6, 31'h7F);
        for (int k = 0; k < 30; k++) step(1'b1, ~src_word());
        chk("inv_no_lock", 64'(locked), 64'd0);
        in_inv = 1'b1;
        for (int k = 0; k < 12; k++) step(1'b1, ~src_word());
        chk("inv_lock", 64'(locked), 64'd1);

        // shutoff at bit 26 with preloaded bit counter
        count_en = 1'b0;
        step(1'b1, ~src_word());
        force dut.o_bit_count = BCW'(64'd67108864 - 64'd48);
        #1;
        release dut.o_bit_count;
        m_bit = BCW'(64'd67108864 - 64'd48);
        shutoff_sel = 4'd1;
        count_en = 1'b1;
        for (int k = 0; k < 8; k++) step(1'b1, ~src_word());
        chk("shutoff_set", 64'(shutoff), 64'd1);
        chk("shutoff_bit_frozen", 64'(bit_count), 64'd67108880);
        clr = 1'b1;
        step(1'b1, ~src_word());
        clr = 1'b0;
        chk("clr_bit", 64'(bit_count), 64'd0);
        chk("clr_ber", 64'(ber_count), 64'd0);
        chk("clr_shutoff", 64'(shutoff), 64'd0);
        chk("clr_keeps_lock", 64'(locked), 64'd1);

        // error counter saturation
        count_en = 1'b0;
        step(1'b1, ~src_word());
        force dut.o_ber_count = BCW'(CMAX - 64'd1);
        #1;
        release dut.o_ber_count;
        m_ber = BCW'(CMAX - 64'd1);
        count_en = 1'b1;
        step(1'b1, ~src_word() ^ 16'h1249);
        for (int k = 0; k < 4; k++) step(1'b1, ~src_word());
        chk("ber_saturated", 64'(ber_count), CMAX);

        // asynchronous reset mid-cycle
        #2;
        rst_n = 1'b0;
        model_reset();
        #1;
        check_zero("async_reset");
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        for (int k = 0; k < 3; k++) step(1'b1, ~src_word());

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
